// File: rtl/aes128_round_sched.sv
// Iterative AES-128 encryptor: one shared round + key-expansion datapath, one round per clock.
// Optional define AES_SCHED_PERF_EN adds the blocks_done completion counter port.
module aes128_round_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [15:0]  blocks_done
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] key_next, round_out;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return r;
    endfunction

    // Inverse as x^254 by square-and-multiply (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, inv;
        p   = x;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r columns.
    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                s[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int unsigned c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int unsigned i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o ^ rk;
    endfunction

    assign key_next  = key_exp(rkey_q, rcon(rnd_q));
    assign round_out = round_fn(state_q, key_next, rnd_q == 4'd9);

    assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN) | (fsm_q == DONE);
    assign data_out  = state_q;
    assign accept    = in_valid & in_ready;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = data_in ^ key_in;
                    rkey_d  = key_in;
                    rnd_d   = '0;
                    fsm_d   = RUN;
                end else if (fsm_q == DONE && out_ready) begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                if (rnd_q > 4'd9) begin
                    fsm_d = IDLE;
                end else begin
                    state_d = round_out;
                    rkey_d  = key_next;
                    rnd_d   = rnd_q + 4'd1;
                    if (rnd_q == 4'd9) fsm_d = DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rnd_q   <= rnd_d;
        end
    end

`ifdef AES_SCHED_PERF_EN
    logic [15:0] blocks_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocks_done_q <= '0;
        end else if (out_valid && out_ready) begin
            blocks_done_q <= blocks_done_q + 16'd1;
        end
    end

    assign blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_aes128_round_sched.sv
// Randomised self-checking bench for aes128_round_sched against a byte-array AES-128 model.
// Define AES_SCHED_PERF_EN to also exercise the blocks_done counter.
module tb_aes128_round_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
`ifdef AES_SCHED_PERF_EN
    logic [15:0]  blocks_done;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  sb [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes128_round_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
`ifdef AES_SCHED_PERF_EN
        ,
        .blocks_done (blocks_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // S-box table from the multiplicative-generator walk (p steps by x3, q by its inverse).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = mul2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[st[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    st[row+4*col] = t[row+4*((col+row)%4)];
            if (r < 10) begin
                for (int col = 0; col < 4; col++) begin
                    for (int j = 0; j < 4; j++) a[j] = st[4*col+j];
                    for (int j = 0; j < 4; j++)
                        st[4*col+j] = mul2(a[j]) ^ mul2(a[(j+1)%4]) ^ a[(j+1)%4]
                                      ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int unsigned n;
        data_in  = pt;
        key_in   = k;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int unsigned lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int unsigned  lat;
        logic [127:0] pt, k, held;

        build_sbox();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;
        rst_n     = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, '0);
        rst_n = 1'b1;
        step();

        // Idle with in_valid low: nothing moves.
        data_in = PT_B;
        key_in  = KEY_B;
        for (int i = 0; i < 3; i++) step();
        check("idle_busy", busy, 0);
        check("idle_data_out", data_out, '0);

        // FIPS-197 App. B with latency.
        send(PT_B, KEY_B);
        check("appb_busy", busy, 1);
        wait_out(lat);
        check("appb_latency", lat, 10);
        check("appb_ct", data_out, CT_B);
        drain();
        check("appb_after_valid", out_valid, 0);
        check("appb_after_busy", busy, 0);

        // FIPS-197 C.1 under 20 cycles of backpressure, with a competing request.
        send(PT_C, KEY_C);
        wait_out(lat);
        check("c1_latency", lat, 10);
        check("c1_ct", data_out, CT_C);
        held     = data_out;
        in_valid = 1'b1;
        data_in  = PT_B;
        key_in   = KEY_B;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_valid", out_valid, 1);
            check("bp_data_out", data_out, held);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        drain();
        check("c1_drained", busy, 0);

        // Back-to-back: C.1 then App. B with out_ready and in_valid continuously high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = PT_C;
        key_in    = KEY_C;
        check("b2b_first_ready", in_ready, 1);
        step();
        data_in = PT_B;
        key_in  = KEY_B;
        lat = 0;
        while (!in_ready && lat < 40) begin
            step();
            lat++;
        end
        check("b2b_gap", lat + 1, 11);
        check("b2b_shared_valid", out_valid, 1);
        check("b2b_ct1", data_out, CT_C);
        step();
        in_valid = 1'b0;
        check("b2b_second_accepted", busy, 1);
        check("b2b_second_running", out_valid, 0);
        wait_out(lat);
        check("b2b_latency2", lat, 10);
        check("b2b_ct2", data_out, CT_B);
        step();
        out_ready = 1'b0;
        check("b2b_idle", busy, 0);

        // Asynchronous reset in the middle of round processing.
        send(PT_B, KEY_B);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data_out", data_out, '0);
        step();
        rst_n = 1'b1;
        step();
        send(PT_C, KEY_C);
        wait_out(lat);
        check("post_rst_latency", lat, 10);
        check("post_rst_ct", data_out, CT_C);
        drain();

        // Random blocks with inputs churning while the rounds run.
        for (int b = 0; b < 8; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            send(pt, k);
            lat = 0;
            while (!out_valid && lat < 40) begin
                data_in  = {$urandom, $urandom, $urandom, $urandom};
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                in_valid = 1'($urandom_range(0, 1));
                check("run_in_ready", in_ready, 0);
                step();
                lat++;
            end
            in_valid = 1'b0;
            check("rand_latency", lat, 10);
            check("rand_ct", data_out, aes_ref(pt, k));
            drain();
        end

`ifdef AES_SCHED_PERF_EN
        do_reset();
        check("perf_reset", blocks_done, 0);
        for (int b = 0; b < 3; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            send(pt, k);
            wait_out(lat);
            check("perf_ct", data_out, aes_ref(pt, k));
            drain();
        end
        check("perf_three", blocks_done, 3);
        force dut.blocks_done_q = 16'hffff;
        step();
        release dut.blocks_done_q;
        check("perf_preload", blocks_done, 16'hffff);
        send(PT_B, KEY_B);
        wait_out(lat);
        drain();
        check("perf_wrap", blocks_done, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes128_round_sched.md
# aes128_round_sched

Iterative AES-128 encryption scheduler. It accepts one plaintext block and key through a valid/ready handshake, then runs pre-whitening, ten rounds and the on-the-fly key expansion one round per clock over a single shared round/key-expansion datapath. It presents the ciphertext through a second valid/ready handshake. It sits between a block source (DMA or CPU register front-end) and a ciphertext sink, replacing ten unrolled round instances with one.

## Interface
- No parameters. Block and key width are fixed at 128 bits; round count is fixed at 10.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  data_in/key_in valid
- in_ready  out  1  scheduler can accept a block
- data_in  in  128  plaintext, byte 0 in [127:120]
- key_in  in  128  cipher key, same byte order
- out_valid  out  1  data_out holds the finished ciphertext
- out_ready  in  1  sink accepts data_out
- data_out  out  128  ciphertext
- busy  out  1  high in RUN or DONE
- blocks_done  out  16  completed-block count (only with AES_SCHED_PERF_EN)

## Operation
- The FSM has three states: IDLE, RUN and DONE. Registers are state_reg[127:0], rkey_reg[127:0] and rnd[3:0].
- IDLE: in_ready=1. On in_valid&in_ready:
  - state_reg <= data_in ^ key_in
  - rkey_reg <= key_in
  - rnd <= 0
  - go to RUN
- RUN: each cycle computes K' = KeyExpand(rkey_reg, rcon[rnd]), with rcon = 01,02,04,08,10,20,40,80,1b,36. Then:
  - state_reg <= SubBytes, ShiftRows, MixColumns and AddRoundKey(K') applied to state_reg. MixColumns is omitted when rnd==9.
  - rkey_reg <= K'
  - rnd <= rnd+1
  - When rnd==9, go to DONE.
- DONE: out_valid=1 and data_out=state_reg. data_out and state_reg stay frozen until out_valid&out_ready.
  - On that handshake, if in_valid is also high, load the new block exactly as from IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from out_ready. in_ready is never high in RUN.
- Inputs are sampled only on the accept edge. data_in and key_in changes at any other time are ignored.
- in_valid held low: the FSM stays in IDLE and no register changes.
- rnd never exceeds 9 in RUN. rnd values 10–15 are unreachable. If rnd is ever found out of range, the FSM goes to IDLE.

## Timing
- Reset values of all outputs and registers:
  - in_ready=1
  - out_valid=0
  - busy=0
  - data_out=0
  - state_reg=0
  - rkey_reg=0
  - rnd=0
  - blocks_done=0
  - FSM in IDLE
- Reset asserted mid-RUN or in DONE discards the block immediately (asynchronous). No output is produced for it.
- Latency: the accept is at edge E0 and round r completes at edge Er. out_valid goes high after E10, i.e. 10 cycles from the accept edge.
- Throughput: with out_ready held high, one block per 11 cycles. Out-handshake and new accept share one edge.
- Backpressure: out_valid stays high indefinitely while out_ready=0, and data_out stays stable.
- The single-round combinational path (S-box, MixColumns, key S-box) is the critical path. No pipelining is required.

## Configuration
- AES_SCHED_PERF_EN defined: the blocks_done port and register exist.
  - blocks_done increments by 1 on every out_valid&out_ready edge.
  - It wraps from 0xFFFF to 0x0000.
  - It resets to 0 and only resets via rst_n.
- AES_SCHED_PERF_EN undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → data_out=3925841d02dc09fbdc118597196a0b32. out_valid must first be high 10 cycles after the accept edge.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Hold out_ready=0 for 20 cycles: out_valid stays 1, data_out stays stable and in_ready stays 0.
- Back-to-back: present the C.1 then App. B vectors with out_ready=1 and in_valid=1 continuously. Required:
  - The second accept coincides with the first out handshake.
  - Accepts are 11 cycles apart.
  - Both ciphertexts are correct and in order.
- Reset mid-op: deassert rst_n at round 5 of the App. B vector. Required:
  - All outputs return to reset values immediately.
  - After release, a fresh C.1 block yields the correct ciphertext.
- Input stability: toggle data_in/key_in randomly during RUN → ciphertext is unaffected. in_valid pulses during RUN are not accepted.
- With AES_SCHED_PERF_EN: complete 3 blocks → blocks_done=3. After preloading 0xFFFF by force and completing one block → blocks_done=0.
